mux4_a: RTL and testbench
=========================

MUX4_A -- requirements
Module: mux4_a

Interface
REQ-001 Parameter: WIDTH, default 4, data width of each input and of each data output.
REQ-002 Parameter: CNT_W, default 8, width of the select-toggle counter.
REQ-003 Port: clk  input  1  rising-edge clock for all registered outputs.
REQ-004 Port: rst_n  input  1  reset; one clock, synchronous, active-low.
REQ-005 Port: mux_in_a  input  WIDTH  data operand A, chosen when mux_sel=0.
REQ-006 Port: mux_in_b  input  WIDTH  data operand B, chosen when mux_sel=1.
REQ-007 Port: mux_sel  input  1  select; 0 chooses A, 1 chooses B.
REQ-008 Port: hold  input  1  freezes the registered outputs when high.
REQ-009 Port: mux_out  output  WIDTH  combinational selected data.
REQ-010 Port: mux_out_q  output  WIDTH  registered copy of mux_out.
REQ-011 Port: sel_toggles  output  CNT_W  count of mux_sel transitions since reset, saturating.
REQ-012 Port: mux_par  output  1  even parity of mux_out_q; present only with MUX4_A_PARITY_EN.

Function
REQ-013 mux_out SHALL equal mux_in_a when mux_sel=0 and mux_in_b when mux_sel=1, with zero cycle latency.
REQ-014 mux_out SHALL depend on no clock, reset or hold state.
REQ-015 mux_out SHALL follow any input change in the same delta, including simultaneous data and select changes.
REQ-016 mux_sel = X or Z SHALL drive mux_out to all-X in simulation; synthesis treats it as don't-care.
REQ-017 On each clk rising edge with rst_n=1 and hold=0, mux_out_q SHALL load mux_out (latency 1 cycle).
REQ-018 With hold=1, mux_out_q and sel_toggles SHALL retain their values.
REQ-019 A registered copy of mux_sel (sel_d) SHALL be kept and updated every non-reset edge, regardless of hold.
REQ-020 sel_toggles SHALL increment by 1 on an edge where mux_sel differs from sel_d and hold=0.
REQ-021 sel_toggles SHALL saturate at all-ones and never wrap.
REQ-022 The first edge after reset release SHALL compare mux_sel against sel_d=0.

Reset
REQ-023 When rst_n=0 at a clk edge, mux_out_q, sel_toggles and sel_d SHALL clear to 0.
REQ-024 With MUX4_A_PARITY_EN defined, mux_par SHALL be 0 during reset.
REQ-025 Reset SHALL take priority over hold.
REQ-026 Reset asserted mid-operation SHALL clear state at the next edge.
REQ-027 mux_out SHALL remain functional during reset.

Configuration
REQ-028 Macro MUX4_A_PARITY_EN defined: port mux_par exists and equals XOR-reduction of mux_out_q, so it updates with mux_out_q.
REQ-029 Macro MUX4_A_PARITY_EN undefined: port mux_par and its logic are absent; all other behaviour is identical.

Structure
REQ-030 Shared package mux4_a_pkg SHALL hold the default WIDTH and CNT_W constants and the select encodings SEL_A=1'b0 and SEL_B=1'b1.
REQ-031 The combinational select SHALL be a sub-module mux4_a_core instantiated once; registers, counter and parity stay in the top level.

Verification
REQ-032 Apply mux_sel=0, A=0000, B=1111 -> mux_out=0000; after the next edge, mux_out_q=0000.
REQ-033 Change mux_sel to 1 (A=0000, B=1111) -> mux_out=1111 immediately; mux_out_q=1111 one edge later; sel_toggles=1.
REQ-034 Set A=0011, B=1100 with mux_sel=1 -> mux_out=1100; then mux_sel=0 -> mux_out=0011; sel_toggles=2.
REQ-035 Set hold=1, then toggle mux_sel three times over three edges -> mux_out_q and sel_toggles unchanged; after hold=0 the counter resumes from its held value.
REQ-036 Toggle mux_sel for 300 edges with CNT_W=8 -> sel_toggles stops at 255; then apply rst_n=0 for 1 edge -> sel_toggles=0 and mux_out_q=0 while mux_out still follows the inputs.
REQ-037 With MUX4_A_PARITY_EN defined and mux_out_q=0111 -> mux_par=1; with mux_out_q=0011 -> mux_par=0.

Source files
------------

// File: rtl/mux4_a_pkg.sv
// Shared constants for the mux4_a slice: default widths and select encodings.
package mux4_a_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_CNT_W = 8;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux4_a_core.sv
// Purely combinational 2:1 data select; an unknown select yields all-X in simulation.
module mux4_a_core
    import mux4_a_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] data_out
);

    always_comb begin
        data_out = 'x;
        case (sel)
            SEL_A:   data_out = in_a;
            SEL_B:   data_out = in_b;
            default: data_out = 'x;
        endcase
    end

endmodule

// File: rtl/mux4_a.sv
// Top level: combinational select plus registered copy, saturating select-toggle counter
// and, when MUX4_A_PARITY_EN is defined, an even-parity output of the registered data.
module mux4_a
    import mux4_a_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] mux_in_a,
    input  logic [WIDTH-1:0] mux_in_b,
    input  logic             mux_sel,
    input  logic             hold,
    output logic [WIDTH-1:0] mux_out,
    output logic [WIDTH-1:0] mux_out_q,
    output logic [CNT_W-1:0] sel_toggles
`ifdef MUX4_A_PARITY_EN
    ,
    output logic             mux_par
`endif
);

    logic sel_d;

    mux4_a_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .sel     (mux_sel),
        .in_a    (mux_in_a),
        .in_b    (mux_in_b),
        .data_out(mux_out)
    );

    // sel_d tracks the select even while held, so releasing hold never counts a stale edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mux_out_q   <= '0;
            sel_toggles <= '0;
            sel_d       <= SEL_A;
        end else begin
            sel_d <= mux_sel;
            if (!hold) begin
                mux_out_q <= mux_out;
                if ((mux_sel != sel_d) && (sel_toggles != {CNT_W{1'b1}}))
                    sel_toggles <= sel_toggles + CNT_W'(1);
            end
        end
    end

`ifdef MUX4_A_PARITY_EN
    assign mux_par = ^mux_out_q;
`endif

endmodule

// File: tb/tb_mux4_a.sv
// Self-checking bench for mux4_a: directed vector table, saturation/reset sequence and
// randomized traffic against a behavioural model. Define MUX4_A_PARITY_EN to cover mux_par.
module tb_mux4_a;

    localparam int WIDTH   = 4;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] mux_in_a;
    logic [WIDTH-1:0] mux_in_b;
    logic             mux_sel;
    logic             hold;
    logic [WIDTH-1:0] mux_out;
    logic [WIDTH-1:0] mux_out_q;
    logic [CNT_W-1:0] sel_toggles;
`ifdef MUX4_A_PARITY_EN
    logic             mux_par;
`endif

    int checks = 0;
    int errors = 0;

    // behavioural model state
    int mQ    = 0;
    int mCnt  = 0;
    int mPrev = 0;

    typedef struct {
        logic             rst_n;
        logic             hold;
        logic             sel;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] exp_out;
        logic [WIDTH-1:0] exp_q;
        int               exp_cnt;
    } vec_t;

    vec_t vecs[13];

    mux4_a #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mux_in_a   (mux_in_a),
        .mux_in_b   (mux_in_b),
        .mux_sel    (mux_sel),
        .hold       (hold),
        .mux_out    (mux_out),
        .mux_out_q  (mux_out_q),
        .sel_toggles(sel_toggles)
`ifdef MUX4_A_PARITY_EN
        ,
        .mux_par    (mux_par)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic h, input logic s,
                                 input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clk);
        rst_n    = r;
        hold     = h;
        mux_sel  = s;
        mux_in_a = a;
        mux_in_b = b;
        #1;
    endtask

    function automatic int modelOut();
        return mux_sel ? int'(mux_in_b) : int'(mux_in_a);
    endfunction

    // Model of one rising edge, written from the behavioural rules rather than the RTL
    task automatic modelEdge();
        if (!rst_n) begin
            mQ = 0; mCnt = 0; mPrev = 0;
        end else begin
            if (!hold) begin
                if (int'(mux_sel) != mPrev) mCnt = (mCnt + 1 > CNT_MAX) ? CNT_MAX : mCnt + 1;
                mQ = modelOut();
            end
            mPrev = int'(mux_sel);
        end
    endtask

    task automatic checkRegs(input string tag, input int expQ, input int expCnt);
        checkOutput({tag, " mux_out_q"}, 32'(mux_out_q), 32'(expQ));
        checkOutput({tag, " sel_toggles"}, 32'(sel_toggles), 32'(expCnt));
`ifdef MUX4_A_PARITY_EN
        checkOutput({tag, " mux_par"}, 32'(mux_par), 32'($countones(expQ) % 2));
`endif
    endtask

    task automatic modelCycle(input string tag, input logic r, input logic h, input logic s,
                              input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit doCheck);
        applyStimulus(r, h, s, a, b);
        if (doCheck) checkOutput({tag, " mux_out"}, 32'(mux_out), 32'(modelOut()));
        @(posedge clk);
        modelEdge();
        #1;
        if (doCheck) checkRegs(tag, mQ, mCnt);
    endtask

    initial begin
        rst_n = 1'b0; hold = 1'b0; mux_sel = 1'b0; mux_in_a = '0; mux_in_b = '0;

        // directed vectors: {rst_n, hold, sel, a, b, exp_out, exp_q, exp_cnt}
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 1};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 4'b0011, 4'b1100, 4'b1100, 4'b1100, 1};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 4'b0011, 4'b1100, 4'b0011, 4'b0011, 2};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 4'b0011, 4'b1100, 4'b1100, 4'b0011, 2};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 4'b0011, 4'b1100, 4'b0011, 4'b0011, 2};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 4'b0011, 4'b1100, 4'b1100, 4'b0011, 2};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 4'b0011, 4'b1100, 4'b0011, 4'b0011, 3};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 4'b0111, 4'b0000, 4'b0111, 4'b0111, 3};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 4'b0011, 4'b0000, 4'b0011, 4'b0011, 3};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 4'b0101, 4'b1010, 4'b1010, 4'b0000, 0};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 4'b0101, 4'b1010, 4'b1010, 4'b1010, 1};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 4'b1001, 4'b0110, 4'b0110, 4'b0110, 1};

        // reset state, with mux_out still live during reset
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b0110, 4'b1001);
        checkOutput("reset mux_out", 32'(mux_out), 32'h9);
        @(posedge clk);
        modelEdge();
        #1;
        checkRegs("reset", 0, 0);

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].rst_n, vecs[i].hold, vecs[i].sel, vecs[i].a, vecs[i].b);
            checkOutput($sformatf("vec%0d mux_out", i), 32'(mux_out), 32'(vecs[i].exp_out));
            @(posedge clk);
            modelEdge();
            #1;
            checkRegs($sformatf("vec%0d", i), int'(vecs[i].exp_q), vecs[i].exp_cnt);
        end

        // saturation: 300 toggling edges, counter must stop at all-ones
        for (int i = 0; i < 300; i++)
            modelCycle("sat", 1'b1, 1'b0, ~mux_sel, 4'(i), 4'(~i), 1'b0);
        checkOutput("sat sel_toggles", 32'(sel_toggles), 32'(CNT_MAX));
        checkOutput("sat model", 32'(mCnt), 32'(CNT_MAX));

        // one-edge reset mid-operation from saturation
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b1110, 4'b0001);
        checkOutput("midreset mux_out", 32'(mux_out), 32'hE);
        @(posedge clk);
        modelEdge();
        #1;
        checkRegs("midreset", 0, 0);
        mux_sel = 1'b1;
        #1;
        checkOutput("midreset mux_out follows", 32'(mux_out), 32'h1);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++)
            modelCycle("rand", 1'($urandom_range(19, 0) != 0), 1'($urandom_range(3, 0) == 0),
                       1'($urandom), 4'($urandom), 4'($urandom), 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
